t_flip_flop: RTL and testbench



---
 rtl/t_flip_flop.sv | 26 ++
 tb/tb_t_flip_flop.sv | 139 +++++++++++++
 2 files changed

// File: rtl/t_flip_flop.sv
// Enable-gated toggle flip-flop: a vector of independent T cells sharing one clock,
// one global enable and an asynchronous active-low reset.
module t_flip_flop #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Each bit follows Q+ = Q ^ (En & T); bits never interact inside the block.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Q <= RESET_VALUE;
        end else if (En) begin
            Q <= Q ^ T;
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: single cell, a 4-bit ripple-free counter built
// from four chained cells, and a WIDTH=4 instance with a fixed toggle mask.
`timescale 1ns/1ps
module tb_t_flip_flop;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       t;
    logic       q;
    logic       qn;
    logic [3:0] cq;
    logic [3:0] cqn;
    logic [3:0] w_t;
    logic [3:0] w_q;
    logic [3:0] w_qn;

    int checks = 0;
    int errors = 0;

    t_flip_flop dut (
        .Clk(clk), .Reset(reset_n), .En(en), .T(t), .Q(q), .Qn(qn)
    );

    // Four single-bit cells wired as a synchronous binary counter.
    t_flip_flop c0 (.Clk(clk), .Reset(reset_n), .En(en), .T(1'b1),
                    .Q(cq[0]), .Qn(cqn[0]));
    t_flip_flop c1 (.Clk(clk), .Reset(reset_n), .En(en), .T(cq[0]),
                    .Q(cq[1]), .Qn(cqn[1]));
    t_flip_flop c2 (.Clk(clk), .Reset(reset_n), .En(en), .T(cq[0] & cq[1]),
                    .Q(cq[2]), .Qn(cqn[2]));
    t_flip_flop c3 (.Clk(clk), .Reset(reset_n), .En(en), .T(cq[0] & cq[1] & cq[2]),
                    .Q(cq[3]), .Qn(cqn[3]));

    t_flip_flop #(.WIDTH(4)) wide (
        .Clk(clk), .Reset(reset_n), .En(en), .T(w_t), .Q(w_q), .Qn(w_qn)
    );

    // Rising edges at 400, 800, 1200 ns ...
    initial begin
        clk = 1'b1;
        forever #200 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        t       = 1'b1;
        w_t     = 4'b1010;
        #1;
        chk("rst_q", {31'd0, q}, 32'd0);
        chk("rst_qn", {31'd0, qn}, 32'd1);
        repeat (2) begin
            tick();
            chk("rst_hold_q", {31'd0, q}, 32'd0);
            chk("rst_hold_qn", {31'd0, qn}, 32'd1);
        end

        // Release reset between edges with En=T=1: toggles 1,0,1.
        #100;
        reset_n = 1'b1;
        en      = 1'b1;
        tick(); chk("tog1", {31'd0, q}, 32'd1);
        tick(); chk("tog2", {31'd0, q}, 32'd0);
        tick(); chk("tog3", {31'd0, q}, 32'd1);
        chk("tog3_qn", {31'd0, qn}, 32'd0);

        // T=0 holds for three edges, then one toggle.
        t = 1'b0;
        repeat (3) begin
            tick(); chk("t0_hold", {31'd0, q}, 32'd1);
        end
        t = 1'b1;
        tick(); chk("t1_tog", {31'd0, q}, 32'd0);
        tick(); chk("t1_tog_back", {31'd0, q}, 32'd1);

        // En=0 freezes even with T=1, re-enable toggles on the next edge.
        en = 1'b0;
        repeat (4) begin
            tick(); chk("en0_hold", {31'd0, q}, 32'd1);
        end
        en = 1'b1;
        tick(); chk("en1_tog", {31'd0, q}, 32'd0);
        tick(); chk("en1_tog2", {31'd0, q}, 32'd1);

        // Asynchronous reset pulse between edges.
        #100;
        reset_n = 1'b0;
        #1;
        chk("async_q", {31'd0, q}, 32'd0);
        chk("async_qn", {31'd0, qn}, 32'd1);
        #50;
        reset_n = 1'b1;
        tick(); chk("after_async", {31'd0, q}, 32'd1);
        tick(); chk("after_async2", {31'd0, q}, 32'd0);

        // Reset asserted at the same instant as a rising edge with En=T=1.
        @(negedge clk);
        #200;
        reset_n = 1'b0;
        #1;
        chk("rst_coincide", {31'd0, q}, 32'd0);
        tick(); chk("rst_low_edge", {31'd0, q}, 32'd0);
        chk("cnt_rst", {28'd0, cq}, 32'd0);
        chk("wide_rst", {28'd0, w_q}, 32'd0);

        // Release away from the edge; counter counts 0..15,0 and wide alternates.
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] exp_cnt;
            logic [3:0] exp_w;
            exp_cnt = 4'(k % 16);
            exp_w   = (k % 2 == 1) ? 4'b1010 : 4'b0000;
            tick();
            chk("cnt", {28'd0, cq}, {28'd0, exp_cnt});
            chk("cnt_n", {28'd0, cqn}, {28'd0, ~exp_cnt});
            chk("wide", {28'd0, w_q}, {28'd0, exp_w});
            chk("wide_n", {28'd0, w_qn}, {28'd0, ~exp_w});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
